mat4_mul_seq: RTL

MAT4_MUL_SEQ -- requirements
Module: mat4_mul_seq

---
 rtl/mat_pkg.sv | 27 ++
 rtl/mat4_mul_seq_dot4.sv | 38 +++
 rtl/mat4_mul_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the sequential 4x4 matrix multiplier: sizes, FSM
// state encoding and the row-major index helper.
package mat_pkg;

    localparam int MAT_N     = 4;
    localparam int MAT_ELEMS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } rc_t;

    // Row-major element index 0..15 -> (row, col).
    function automatic rc_t idx_to_rc(input logic [3:0] idx);
        rc_t rc;
        rc.row = idx[3:2];
        rc.col = idx[1:0];
        return rc;
    endfunction

endpackage

// File: rtl/mat4_mul_seq_dot4.sv
// Combinational 4-term unsigned dot product with truncate/saturate output
// rule. The sum is carried at 2*DATA_W+2 bits so it cannot overflow.
module dot4
    import mat_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8,
    parameter int SAT    = 0
) (
    input  logic [MAT_N*DATA_W-1:0] b_row,
    input  logic [MAT_N*DATA_W-1:0] a_col,
    output logic [OUT_W-1:0]        o
);

    localparam int SUM_W = 2*DATA_W + 2;
    localparam int EXT_W = (OUT_W > SUM_W) ? OUT_W : SUM_W;

    logic [2*DATA_W-1:0] prod [MAT_N];
    logic [SUM_W-1:0]    sum;
    logic [EXT_W-1:0]    sum_ext;
    logic [EXT_W-1:0]    max_v;

    always_comb begin
        sum = '0;
        for (int k = 0; k < MAT_N; k++) begin
            prod[k] = (2*DATA_W)'(b_row[k*DATA_W +: DATA_W]) *
                      (2*DATA_W)'(a_col[k*DATA_W +: DATA_W]);
            sum     = sum + SUM_W'(prod[k]);
        end
        // Widen to a common width so both truncation and clamping work
        // whether OUT_W is narrower or wider than the internal sum.
        sum_ext = EXT_W'(sum);
        max_v   = (EXT_W'(1) << OUT_W) - EXT_W'(1);
        o       = ((SAT != 0) && (sum_ext > max_v)) ? max_v[OUT_W-1:0]
                                                    : sum_ext[OUT_W-1:0];
    end

endmodule

// File: rtl/mat4_mul_seq.sv
// Sequential 4x4 matrix multiply O = B*A, one output element per cycle
// through a single shared dot4 unit, with valid/ready operand and result ports.
module mat4_mul_seq
    import mat_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8,
    parameter int SAT    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MAT_ELEMS*DATA_W-1:0] a_flat,
    input  logic [MAT_ELEMS*DATA_W-1:0] b_flat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MAT_ELEMS*OUT_W-1:0]  o_flat,
    output logic                        busy
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid must not depend on ready within the same cycle.

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CALC = ST_CALC;
    localparam logic [1:0] S_DONE = ST_DONE;
    localparam int         ROW_W  = MAT_N*DATA_W;

    logic [1:0]                  state;
    logic [3:0]                  idx;
    logic [MAT_ELEMS*DATA_W-1:0] a_reg;
    logic [MAT_ELEMS*DATA_W-1:0] b_reg;
    logic [MAT_ELEMS*OUT_W-1:0]  o_reg;

    rc_t              rc;
    logic [ROW_W-1:0] b_row;
    logic [ROW_W-1:0] a_col;
    logic [OUT_W-1:0] elem;

    // O[r][c] uses row r of B (contiguous) and column c of A (strided).
    always_comb begin
        rc    = idx_to_rc(idx);
        b_row = b_reg[int'(rc.row)*ROW_W +: ROW_W];
        a_col = '0;
        for (int k = 0; k < MAT_N; k++) begin
            a_col[k*DATA_W +: DATA_W] =
                a_reg[(k*MAT_N + int'(rc.col))*DATA_W +: DATA_W];
        end
    end

    dot4 #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .SAT    (SAT)
    ) u_dot4 (
        .b_row (b_row),
        .a_col (a_col),
        .o     (elem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            o_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= a_flat;
                        b_reg <= b_flat;
                        idx   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    o_reg[int'(idx)*OUT_W +: OUT_W] <= elem;
                    idx <= idx + 4'd1;
                    if (idx == 4'd15) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE) && !rst;
    assign busy      = (state == S_CALC);
    assign out_valid = (state == S_DONE);
    assign o_flat    = o_reg;

endmodule
